dccm_axi_responder: RTL and testbench
=====================================

# dccm_axi_responder

AXI4-Lite responder that exposes the data closely-coupled memory (DCCM) to the system interconnect. It is the far end of the load/store path: the core and fetch logic act as AXI initiators through the crossbar, and this block terminates their transactions into a single-port synchronous SRAM bank. It handles one outstanding transaction at a time, arbitrates reads against writes, and returns OKAY or SLVERR responses.

## Interface
- `ADDR_W`, default 32: AXI address width. Addresses are byte offsets; the crossbar has already stripped the region base.
- `DATA_W`, default 32: data width. Fixed at 32 for this revision; `DATA_W/8` strobe bits.
- `DEPTH`, default 1024: SRAM depth in words. Must be a power of two.
- Clock and reset:
  - `clk`  in  1  single clock.
  - `rst`  in  1  asynchronous, active-high reset.
- Write address channel:
  - `s_axi_awvalid` in 1, `s_axi_awready` out 1, `s_axi_awaddr` in ADDR_W.
- Write data channel:
  - `s_axi_wvalid` in 1, `s_axi_wready` out 1, `s_axi_wdata` in 32, `s_axi_wstrb` in 4.
- Write response channel:
  - `s_axi_bvalid` out 1, `s_axi_bready` in 1, `s_axi_bresp` out 2.
- Read address channel:
  - `s_axi_arvalid` in 1, `s_axi_arready` out 1, `s_axi_araddr` in ADDR_W.
- Read data channel:
  - `s_axi_rvalid` out 1, `s_axi_rready` in 1, `s_axi_rdata` out 32, `s_axi_rresp` out 2.

## Operation
- FSM states: IDLE, WRITE, READ_MEM, READ_RESP, WRITE_RESP.
- Address and data holding registers:
  - One-entry AW buffer and one-entry W buffer, filled independently.
  - `awready` is high iff state is IDLE and the AW buffer is empty. `wready` follows the same rule with the W buffer.
  - AW and W may arrive in either order or in the same cycle.
- Arbitration in IDLE:
  - A write is eligible when both buffers are full.
  - A read is eligible when `arvalid` is high. `arready` is high in IDLE only when the arbiter selects the read.
  - If both are eligible, a 1-bit priority flag decides. The flag resets to favor the write and toggles after every completed transaction.
- Write path:
  - IDLE goes to WRITE. The SRAM is written with byte enables equal to `wstrb` at the end of the WRITE cycle, and both buffers are cleared.
  - WRITE goes to WRITE_RESP with `bvalid=1`. The state holds until `bready`, then returns to IDLE.
  - `wstrb=0` is a legal no-op write and still gets a response.
- Read path:
  - The AR handshake captures the word index `araddr[log2(DEPTH)+1:2]`. The SRAM is read in READ_MEM.
  - In READ_RESP, `rvalid=1` and `rdata` is registered. The state holds until `rready`, then returns to IDLE.
- Address bits [1:0] are ignored; accesses are word-aligned.
- Backpressure: `bvalid`, `bresp`, `rvalid`, `rdata` and `rresp` stay stable until their handshake completes.
- Reset:
  - Async assertion forces IDLE, empties both buffers, and sets the priority flag to favor the write.
  - All outputs go to 0: valids, readies, `bresp`, `rresp`, `rdata`.
  - SRAM contents are not cleared. A transaction interrupted by reset is dropped with no response.

## Timing
- Readies are low during reset. They may go high on the first rising edge after `rst` deasserts.
- Read, AR handshake in cycle N:
  - Cycle N+1: READ_MEM.
  - Cycle N+2: `rvalid` high.
  - Next AR can be accepted in the cycle after the R handshake.
- Write, last of AW/W accepted in cycle N:
  - Cycle N+1: IDLE arbitration.
  - Cycle N+2: WRITE; SRAM updated at the end of this cycle.
  - Cycle N+3: `bvalid` high.
- Read-after-write to the same address returns the new data, because the write completes before the read is accepted.

## Configuration
- `DCCM_AXI_ERR_RESP_EN` defined:
  - An address at or above DEPTH*4 (any bit above `log2(DEPTH)+1` set) is out of range.
  - Out-of-range writes are dropped with `bresp=2'b10` (SLVERR).
  - Out-of-range reads skip the SRAM, return `rdata=0` and `rresp=2'b10`.
  - Latency is unchanged.
- Not defined: upper address bits are ignored, so the index wraps modulo DEPTH, and responses are always `2'b00` (OKAY).

## Structure
- Shared package `dccm_axi_pkg`: FSM state enum, AXI response constants (OKAY=2'b00, SLVERR=2'b10), and the default DEPTH.
- Sub-module `dccm_sram_bank`: single-port, synchronous-read, byte-write-enable SRAM of DEPTH×32, inferred for FPGA or technology RAM.
- The top level contains the FSM, buffers, arbiter and response registers.

## Test plan
- Write 0xDEADBEEF to 0x10 with strobe 0xF, then read 0x10: `bresp=0`, `rdata=0xDEADBEEF`, `rvalid` two cycles after the AR handshake.
- Send W three cycles before AW, then a strobe-0x2 write of 0x0000AA00 to the same word: a later read returns 0xDEADAAEF.
- Hold AW/W and AR valid together from reset: the write completes first, the read second, and order alternates over 4 pairs.
- Hold `rready` and `bready` low for 5 cycles: data and responses stay stable, and no new AW/W/AR is accepted.
- With `DCCM_AXI_ERR_RESP_EN`, read or write 0x1000 at DEPTH=1024: SLVERR, `rdata=0`, word 0 unmodified. Without the macro, the same write lands in word 0 with OKAY.
- Assert `rst` during READ_MEM: `rvalid` stays 0, the state returns to IDLE, and prior SRAM contents survive.

Source files
------------

// File: rtl/dccm_axi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dccm_axi_pkg: shared FSM state, AXI response codes, default DCCM depth.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package dccm_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_READ_MEM   = 3'd2,
    ST_READ_RESP  = 3'd3,
    ST_WRITE_RESP = 3'd4
  } state_t;

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  localparam int c_default_depth = 1024;

endpackage
`default_nettype wire

// File: rtl/dccm_sram_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dccm_sram_bank: single-port DEPTHx32 SRAM, synchronous read, byte WE.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dccm_sram_bank
  import dccm_axi_pkg::*;
#(
  parameter int DEPTH = c_default_depth
) (
  input  logic                     clk,
  input  logic                     i_en,
  input  logic                     i_we,
  input  logic [3:0]               i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // No reset on the array or read port so the tools can map it onto block RAM.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int i = 0; i < 4; i++) begin
          if (i_be[i]) begin
            r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dccm_axi_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dccm_axi_responder: AXI4-Lite responder terminating into the DCCM SRAM.  |
// | Option macro: DCCM_AXI_ERR_RESP_EN (SLVERR on out-of-range addresses).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dccm_axi_responder
  import dccm_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = c_default_depth
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  output logic [1:0]          s_axi_bresp,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp
);

  localparam int c_idx_w = $clog2(DEPTH);

  state_t                r_state;
  logic                  r_active;
  logic                  r_aw_full, r_aw_oor, r_w_full, r_rd_oor, r_prio_rd;
  logic [c_idx_w-1:0]    r_aw_idx, r_rd_idx;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic                  r_bvalid, r_rvalid, r_rdata_en;
  logic [1:0]            r_bresp, r_rresp;

  logic                  w_idle, w_aw_hs, w_w_hs, w_ar_hs, w_wr_pending, w_wr_go;
  logic                  w_aw_oor, w_ar_oor;
  logic                  w_mem_en, w_mem_we;
  logic [c_idx_w-1:0]    w_mem_addr;
  logic [DATA_W-1:0]     w_mem_rdata;
  logic                  w_unused;

`ifdef DCCM_AXI_ERR_RESP_EN
  assign w_aw_oor = |s_axi_awaddr[ADDR_W-1:c_idx_w+2];
  assign w_ar_oor = |s_axi_araddr[ADDR_W-1:c_idx_w+2];
`else
  assign w_aw_oor = 1'b0;
  assign w_ar_oor = 1'b0;
`endif

  assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                      s_axi_awaddr[ADDR_W-1:c_idx_w+2], s_axi_araddr[ADDR_W-1:c_idx_w+2]};

  // r_active keeps every ready low until the first edge after reset release.
  assign w_idle        = r_active && (r_state == ST_IDLE);
  assign s_axi_awready = w_idle && !r_aw_full;
  assign s_axi_wready  = w_idle && !r_w_full;
  assign w_aw_hs       = s_axi_awvalid && s_axi_awready;
  assign w_w_hs        = s_axi_wvalid && s_axi_wready;

  // A write whose buffers complete this cycle already counts against the read,
  // so a favoured write is not overtaken while its last beat is landing.
  assign w_wr_pending  = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);
  assign s_axi_arready = w_idle && s_axi_arvalid && (!w_wr_pending || r_prio_rd);
  assign w_ar_hs       = s_axi_arvalid && s_axi_arready;
  assign w_wr_go       = w_idle && r_aw_full && r_w_full && !w_ar_hs;

  assign w_mem_en   = ((r_state == ST_WRITE) && !r_aw_oor) ||
                      ((r_state == ST_READ_MEM) && !r_rd_oor);
  assign w_mem_we   = (r_state == ST_WRITE);
  assign w_mem_addr = (r_state == ST_WRITE) ? r_aw_idx : r_rd_idx;

  dccm_sram_bank #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk     (clk),
    .i_en    (w_mem_en),
    .i_we    (w_mem_we),
    .i_be    (r_wstrb),
    .i_addr  (w_mem_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_active   <= 1'b0;
      r_aw_full  <= 1'b0;
      r_aw_oor   <= 1'b0;
      r_aw_idx   <= '0;
      r_w_full   <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rd_idx   <= '0;
      r_rd_oor   <= 1'b0;
      r_prio_rd  <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= c_resp_okay;
      r_rvalid   <= 1'b0;
      r_rresp    <= c_resp_okay;
      r_rdata_en <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= s_axi_awaddr[c_idx_w+1:2];
        r_aw_oor  <= w_aw_oor;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_ar_hs) begin
            r_state  <= ST_READ_MEM;
            r_rd_idx <= s_axi_araddr[c_idx_w+1:2];
            r_rd_oor <= w_ar_oor;
          end else if (w_wr_go) begin
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_aw_full <= 1'b0;
          r_w_full  <= 1'b0;
          r_bvalid  <= 1'b1;
          r_bresp   <= r_aw_oor ? c_resp_slverr : c_resp_okay;
          r_state   <= ST_WRITE_RESP;
        end
        ST_WRITE_RESP: begin
          if (s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= c_resp_okay;
            r_prio_rd <= ~r_prio_rd;
            r_state   <= ST_IDLE;
          end
        end
        ST_READ_MEM: begin
          r_rvalid   <= 1'b1;
          r_rresp    <= r_rd_oor ? c_resp_slverr : c_resp_okay;
          r_rdata_en <= !r_rd_oor;
          r_state    <= ST_READ_RESP;
        end
        ST_READ_RESP: begin
          if (s_axi_rready) begin
            r_rvalid   <= 1'b0;
            r_rresp    <= c_resp_okay;
            r_rdata_en <= 1'b0;
            r_prio_rd  <= ~r_prio_rd;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The SRAM read register holds its word through READ_RESP; gating keeps rdata 0 otherwise.
  assign s_axi_rdata  = r_rdata_en ? w_mem_rdata : '0;
  assign s_axi_rvalid = r_rvalid;
  assign s_axi_rresp  = r_rresp;
  assign s_axi_bvalid = r_bvalid;
  assign s_axi_bresp  = r_bresp;

endmodule
`default_nettype wire

// File: tb/tb_dccm_axi_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dccm_axi_responder: randomized scoreboard bench for the DCCM responder.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dccm_axi_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;

  dccm_axi_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int rmode = 0;   // 0: always ready, 1: random, 2: held low
  bit wlat_en = 0;

  logic [31:0] mem_model [DEPTH];
  logic [31:0] aw_q [$];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];
  logic [33:0] exp_r_q [$];
  int          order_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit is_oor(input logic [31:0] a);
`ifdef DCCM_AXI_ERR_RESP_EN
    return a >= DEPTH * 4;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] res = old;
    for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = nw[8*b +: 8];
    return res;
  endfunction

  // Bus monitor and scoreboard: observes handshakes, predicts, compares.
  bit          r_hold, b_hold, b_prev, lat_wait;
  logic [33:0] r_held, e_r;
  logic [1:0]  b_held;
  int          ar_cyc, last_acc_cyc;
  always @(negedge clk) begin
    if (rst) begin
      r_hold = 0; b_hold = 0; b_prev = 0; lat_wait = 0;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin aw_q.push_back(s_axi_awaddr); last_acc_cyc = cyc; end
      if (s_axi_wvalid && s_axi_wready) begin
        wd_q.push_back(s_axi_wdata); ws_q.push_back(s_axi_wstrb); last_acc_cyc = cyc;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        if (is_oor(s_axi_araddr)) exp_r_q.push_back({2'b10, 32'h0});
        else exp_r_q.push_back({2'b00, mem_model[word_idx(s_axi_araddr)]});
        ar_cyc = cyc; lat_wait = 1;
      end
      if (lat_wait && (s_axi_rvalid || cyc - ar_cyc >= 2)) begin
        check("rvalid_at_ar_plus_2", {31'd0, s_axi_rvalid && (cyc - ar_cyc == 2)}, 1);
        lat_wait = 0;
      end
      if (s_axi_rvalid) begin
        if (r_hold) begin
          check("rdata_stable", s_axi_rdata, r_held[31:0]);
          check("rresp_stable", {30'd0, s_axi_rresp}, {30'd0, r_held[33:32]});
        end
        if (s_axi_rready) begin
          if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
          else begin
            e_r = exp_r_q.pop_front();
            check("rdata", s_axi_rdata, e_r[31:0]);
            check("rresp", {30'd0, s_axi_rresp}, {30'd0, e_r[33:32]});
          end
          order_q.push_back(1); r_hold = 0;
        end else begin
          r_hold = 1; r_held = {s_axi_rresp, s_axi_rdata};
        end
      end else if (r_hold) begin
        check("rvalid_dropped", 0, 1); r_hold = 0;
      end
      if (wlat_en && s_axi_bvalid && !b_prev) check("b_latency", cyc - last_acc_cyc, 3);
      b_prev = s_axi_bvalid;
      if (s_axi_bvalid) begin
        if (b_hold) check("bresp_stable", {30'd0, s_axi_bresp}, {30'd0, b_held});
        if (s_axi_bready) begin
          if (aw_q.size() == 0 || wd_q.size() == 0) check("b_unexpected", 1, 0);
          else begin
            logic [31:0] a; logic [31:0] d; logic [3:0] s;
            a = aw_q.pop_front(); d = wd_q.pop_front(); s = ws_q.pop_front();
            check("bresp", {30'd0, s_axi_bresp}, is_oor(a) ? 32'd2 : 32'd0);
            if (!is_oor(a)) mem_model[word_idx(a)] = merge(mem_model[word_idx(a)], d, s);
          end
          order_q.push_back(0); b_hold = 0;
        end else begin
          b_hold = 1; b_held = s_axi_bresp;
        end
      end else if (b_hold) begin
        check("bvalid_dropped", 0, 1); b_hold = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0: begin s_axi_rready = 1; s_axi_bready = 1; end
      1: begin s_axi_rready = ($urandom_range(0, 3) != 0); s_axi_bready = ($urandom_range(0, 3) != 0); end
      default: begin s_axi_rready = 0; s_axi_bready = 0; end
    endcase
  end

  // All stimulus tasks are entered and left just after a rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic aw_send(input logic [31:0] a, input int dly);
    bit hs; int n = 0;
    repeat (dly) step();
    s_axi_awvalid = 1; s_axi_awaddr = a;
    do begin
      @(negedge clk); hs = s_axi_awready; step(); n++;
    end while (!hs && n < 200);
    if (!hs) check("aw_timeout", 0, 1);
    s_axi_awvalid = 0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit hs; int n = 0;
    repeat (dly) step();
    s_axi_wvalid = 1; s_axi_wdata = d; s_axi_wstrb = s;
    do begin
      @(negedge clk); hs = s_axi_wready; step(); n++;
    end while (!hs && n < 200);
    if (!hs) check("w_timeout", 0, 1);
    s_axi_wvalid = 0;
  endtask

  task automatic ar_send(input logic [31:0] a, input int dly);
    bit hs; int n = 0;
    repeat (dly) step();
    s_axi_arvalid = 1; s_axi_araddr = a;
    do begin
      @(negedge clk); hs = s_axi_arready; step(); n++;
    end while (!hs && n < 200);
    if (!hs) check("ar_timeout", 0, 1);
    s_axi_arvalid = 0;
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
    fork
      aw_send(a, aw_dly);
      w_send(d, s, w_dly);
    join
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_r_q.size() != 0 || aw_q.size() != 0 || wd_q.size() != 0 ||
            s_axi_bvalid || s_axi_rvalid) && n < 300) begin
      step(); n++;
    end
    if (n >= 300) check("drain_timeout", 0, 1);
  endtask

  task automatic clear_sb();
    aw_q.delete(); wd_q.delete(); ws_q.delete(); exp_r_q.delete(); order_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
    s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_rready = 0; s_axi_bready = 0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", {31'd0, s_axi_awready}, 0);
    check("rst_wready",  {31'd0, s_axi_wready}, 0);
    check("rst_arready", {31'd0, s_axi_arready}, 0);
    check("rst_bvalid",  {31'd0, s_axi_bvalid}, 0);
    check("rst_rvalid",  {31'd0, s_axi_rvalid}, 0);
    check("rst_bresp",   {30'd0, s_axi_bresp}, 0);
    check("rst_rresp",   {30'd0, s_axi_rresp}, 0);
    check("rst_rdata",   s_axi_rdata, 0);
    rst = 0;
    step();
    @(negedge clk);
    check("awready_after_rst", {31'd0, s_axi_awready}, 1);
    step();

    for (int i = 0; i < 16; i++) write_txn(i * 4, $urandom, 4'hF, 0, 0);
    wait_idle();

    // Basic write then read, with exact latencies.
    wlat_en = 1;
    write_txn(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    wait_idle();
    wlat_en = 0;
    ar_send(32'h10, 0);
    wait_idle();

    // W well ahead of AW, then a single-byte merge into the earlier word.
    write_txn(32'h20, 32'h11223344, 4'hF, 3, 0);
    write_txn(32'h10, 32'h0000AA00, 4'h2, 0, 0);
    ar_send(32'h10, 0);
    wait_idle();

    // Writes and reads held valid from reset must complete alternately, write first.
    rst = 1; clear_sb();
    fork
      for (int k = 0; k < 4; k++) write_txn((20 + k) * 4, $urandom, 4'hF, 0, 0);
      for (int k = 0; k < 4; k++) ar_send(k * 4, 0);
      begin
        @(negedge clk);
        check("rst_hold_awready", {31'd0, s_axi_awready}, 0);
        check("rst_hold_arready", {31'd0, s_axi_arready}, 0);
        rst = 0;
      end
    join
    wait_idle();
    check("order_count", order_q.size(), 8);
    for (int i = 0; i < 8 && i < order_q.size(); i++) check("order_alt", order_q[i], i % 2);

    // Backpressure on B, then on R: nothing new accepted while a response waits.
    rmode = 2;
    write_txn(32'h30, 32'hA5A5_5A5A, 4'hF, 0, 0);
    for (int n = 0; n < 50 && !s_axi_bvalid; n++) step();
    check("bvalid_seen", {31'd0, s_axi_bvalid}, 1);
    fork
      write_txn(32'h34, 32'h0BAD_F00D, 4'hF, 0, 0);
      ar_send(32'h30, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_b_no_accept", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 0);
          step();
        end
        rmode = 0;
      end
    join
    wait_idle();
    rmode = 2;
    ar_send(32'h34, 0);
    for (int n = 0; n < 50 && !s_axi_rvalid; n++) step();
    check("rvalid_seen", {31'd0, s_axi_rvalid}, 1);
    fork
      write_txn(32'h38, 32'h1357_9BDF, 4'hF, 0, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_r_no_accept", {30'd0, s_axi_awready, s_axi_wready}, 0);
          step();
        end
        rmode = 0;
      end
    join
    wait_idle();

    // One past the top of the bank: SLVERR with the option, alias of word 0 without.
    write_txn(32'h1000, 32'hCAFE_F00D, 4'hF, 0, 0);
    ar_send(32'h1000, 0);
    ar_send(32'h0, 0);
    wait_idle();

    // Reset in READ_MEM drops the read; SRAM keeps its contents.
    ar_send(32'h10, 0);
    rst = 1; clear_sb();
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_rvalid", {31'd0, s_axi_rvalid}, 0);
    end
    rst = 0;
    step();
    @(negedge clk);
    check("post_rst_rvalid", {31'd0, s_axi_rvalid}, 0);
    step();
    ar_send(32'h10, 0);
    wait_idle();

    // Randomized mix with random backpressure and sparse out-of-range addresses.
    rmode = 1;
    for (int t = 0; t < 80; t++) begin
      logic [31:0] a;
      a = $urandom_range(0, 15) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
      if ($urandom_range(0, 1) == 0)
        write_txn(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        ar_send(a, $urandom_range(0, 2));
    end
    rmode = 0;
    wait_idle();
    check("final_r_queue", exp_r_q.size(), 0);
    check("final_w_queue", aw_q.size() + wd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
